alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 61 ++++++
 rtl/alu_pipe.sv | 80 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op encodings, flag bit positions and the S1 control payload for alu_pipe.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRA = 3'b111
    } alu_op_e;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef struct packed {
        alu_op_e op;
        logic    mux_sel;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result plus {V,C,N,Z} flags for one operand pair.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  alu_op_e           op,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   sh;
    logic             carry;
    logic             ovf;

    // One extra bit on each side exposes carry-out (ADD) and borrow (SUB).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign sh   = b[SHW-1:0];

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_XOR: result = a ^ b;
            OP_SLT: result[0] = $signed(a) < $signed(b);
            OP_SLL: result = a << sh;
            OP_SRA: result = $unsigned($signed(a) >>> sh);
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[MSB];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 captures operands, S2 computes and registers results.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [2:0]        alu_op,
    input  logic              mux_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  alu_out,
    output logic [WIDTH-1:0]  mux_out,
    output logic [FLAG_W-1:0] flags
);

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    alu_ctrl_t         s1_ctrl;

    logic              s2_adv_c;
    logic              accept_c;
    logic [WIDTH-1:0]  res_c;
    logic [FLAG_W-1:0] flg_c;

    // S2 frees up when empty or being drained; S1 frees up when empty or moving into S2.
    assign s2_adv_c = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_adv_c);
    assign accept_c = in_valid && in_ready;

    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_ctrl.op),
        .result (res_c),
        .flags  (flg_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_ctrl   <= '{op: OP_AND, mux_sel: 1'b0};
            out_valid <= 1'b0;
            alu_out   <= '0;
            mux_out   <= '0;
            flags     <= '0;
        end else begin
            if (s2_adv_c) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    alu_out <= res_c;
                    mux_out <= s1_ctrl.mux_sel ? s1_b : res_c;
                    flags   <= flg_c;
                end
            end
            // A new set may replace the one moving to S2 in the same cycle.
            if (accept_c) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_ctrl  <= '{op: alu_op_e'(alu_op), mux_sel: mux_sel};
            end else if (s2_adv_c) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule
